// File: rtl/counter_pkg.sv
// Shared types and range helper for bounded_counter and its step datapath.
package counter_pkg;

   typedef enum logic [1:0] {CNT_HOLD, CNT_LOAD, CNT_UP, CNT_DOWN} cnt_op_e;

   function automatic bit in_range(input int val, input int lo, input int hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/bounded_counter_if.sv
// Request/status bundle of bounded_counter; master drives requests, slave is the counter.
interface bounded_counter_if #(
   parameter int width_p = 8
);
   logic               up_i;
   logic               down_i;
   logic [width_p-1:0] step_i;
   logic               load_i;
   logic [width_p-1:0] load_val_i;
   logic [width_p-1:0] count_o;
   logic [width_p-1:0] next_count_o;
   logic               at_max_o;
   logic               at_min_o;
   logic               overflow_o;
   logic               underflow_o;

   modport master (
      output up_i, down_i, step_i, load_i, load_val_i,
      input  count_o, next_count_o, at_max_o, at_min_o, overflow_o, underflow_o
   );

   modport slave (
      input  up_i, down_i, step_i, load_i, load_val_i,
      output count_o, next_count_o, at_max_o, at_min_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/bounded_step.sv
// Combinational next value for one up/down step within [min_val_p, max_val_p].
// Wraps by default; BOUNDED_COUNTER_SAT_EN clips at the bounds instead (event flags the crossing).
module bounded_step #(
   parameter int width_p   = 8,
   parameter int min_val_p = 0,
   parameter int max_val_p = (1 << width_p) - 1
) (
   input  logic [width_p-1:0] count_i,
   input  logic [width_p-1:0] step_i,
   input  logic               up_i,
   output logic [width_p-1:0] next_o,
   output logic               event_o
);
   localparam int               RangeP = max_val_p - min_val_p + 1;
   localparam logic [width_p:0] MinW   = min_val_p[width_p:0];
   localparam logic [width_p:0] MaxW   = max_val_p[width_p:0];
   localparam logic [width_p:0] RangeW = RangeP[width_p:0];

   logic [width_p:0] cnt_w;
   logic [width_p:0] stp_w;
   logic [width_p:0] sum_w;
   logic [width_p:0] res_w;
   logic             res_unused;

   // One extra bit keeps count+step and count+R-step from truncating.
   always_comb begin
      cnt_w   = {1'b0, count_i};
      stp_w   = {1'b0, step_i};
      sum_w   = cnt_w + stp_w;
      event_o = 1'b0;
      res_w   = cnt_w;
      if (up_i) begin
         event_o = (sum_w > MaxW);
`ifdef BOUNDED_COUNTER_SAT_EN
         res_w = event_o ? MaxW : sum_w;
`else
         res_w = event_o ? (sum_w - RangeW) : sum_w;
`endif
      end else begin
         event_o = (cnt_w < (MinW + stp_w));
`ifdef BOUNDED_COUNTER_SAT_EN
         res_w = event_o ? MinW : (cnt_w - stp_w);
`else
         res_w = event_o ? (cnt_w + RangeW - stp_w) : (cnt_w - stp_w);
`endif
      end
   end

   assign next_o     = res_w[width_p-1:0];
   assign res_unused = res_w[width_p];

endmodule

// File: rtl/bounded_counter.sv
// Up/down counter confined to [min_val_p, max_val_p] with step, clamped load and
// registered overflow/underflow pulses; BOUNDED_COUNTER_SAT_EN selects saturation over wrap.
module bounded_counter
   import counter_pkg::*;
#(
   parameter int width_p     = 8,
   parameter int min_val_p   = 0,
   parameter int max_val_p   = (1 << width_p) - 1,
   parameter int reset_val_p = 0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   bounded_counter_if.slave  bus
);
   localparam int                 RangeP = max_val_p - min_val_p + 1;
   localparam logic [width_p-1:0] MinV   = min_val_p[width_p-1:0];
   localparam logic [width_p-1:0] MaxV   = max_val_p[width_p-1:0];
   localparam logic [width_p-1:0] RstV   = reset_val_p[width_p-1:0];

   if (!(min_val_p < max_val_p) || !in_range(reset_val_p, min_val_p, max_val_p)) begin : g_param_chk
      $error("bounded_counter: need min_val_p < max_val_p and reset_val_p inside the range");
   end

   cnt_op_e            op;
   logic [width_p-1:0] count_q, count_d;
   logic [width_p-1:0] load_clamped;
   logic [width_p-1:0] step_nxt;
   logic               step_evt;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;

   // A zero step or conflicting up/down is a hold, so it never pulses.
   always_comb begin
      op = CNT_HOLD;
      if (bus.load_i) begin
         op = CNT_LOAD;
      end else if ((bus.up_i ^ bus.down_i) && (bus.step_i != '0)) begin
         op = bus.up_i ? CNT_UP : CNT_DOWN;
      end
   end

   always_comb begin
      load_clamped = bus.load_val_i;
      if (bus.load_val_i < MinV) begin
         load_clamped = MinV;
      end else if (bus.load_val_i > MaxV) begin
         load_clamped = MaxV;
      end
   end

   bounded_step #(
      .width_p   (width_p),
      .min_val_p (min_val_p),
      .max_val_p (max_val_p)
   ) u_step (
      .count_i (count_q),
      .step_i  (bus.step_i),
      .up_i    (op == CNT_UP),
      .next_o  (step_nxt),
      .event_o (step_evt)
   );

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (reset_i) begin
         count_d = RstV;
      end else begin
         unique case (op)
            CNT_LOAD: count_d = load_clamped;
            CNT_UP: begin
               count_d = step_nxt;
               ovf_d   = step_evt;
            end
            CNT_DOWN: begin
               count_d = step_nxt;
               unf_d   = step_evt;
            end
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= RstV;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.count_o      = count_q;
   assign bus.next_count_o = count_d;
   assign bus.at_max_o     = (count_q == MaxV);
   assign bus.at_min_o     = (count_q == MinV);
   assign bus.overflow_o   = ovf_q;
   assign bus.underflow_o  = unf_q;

   // Steps larger than the range have no defined result.
   step_le_range: assert property (@(posedge clk_i) disable iff (reset_i)
      ((op == CNT_UP) || (op == CNT_DOWN)) |-> in_range(int'(bus.step_i), 0, RangeP));

endmodule

// File: tb/tb_bounded_counter.sv
// Directed plus random checks of bounded_counter against an arithmetic range model.
module tb_bounded_counter;
   localparam int W    = 4;
   localparam int MINV = 2;
   localparam int MAXV = 11;
   localparam int RSTV = 5;
   localparam int R    = MAXV - MINV + 1;

   logic clk_i;
   logic reset_i;

   bounded_counter_if #(.width_p(W)) bus ();

   bounded_counter #(
      .width_p     (W),
      .min_val_p   (MINV),
      .max_val_p   (MAXV),
      .reset_val_p (RSTV)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int m_cnt  = RSTV;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Range arithmetic on offsets from MINV: wrap is modulo R, saturation clips.
   task automatic model_eval(input bit r, input bit l, input bit u, input bit d,
                             input int s, input int lv,
                             output int nxt, output bit ov, output bit un);
      int t;
      nxt = m_cnt;
      ov  = 1'b0;
      un  = 1'b0;
      if (r) begin
         nxt = RSTV;
      end else if (l) begin
         nxt = (lv < MINV) ? MINV : ((lv > MAXV) ? MAXV : lv);
      end else if (u && !d && s != 0) begin
         t  = m_cnt - MINV + s;
         ov = (t >= R);
`ifdef BOUNDED_COUNTER_SAT_EN
         nxt = ov ? MAXV : m_cnt + s;
`else
         nxt = MINV + (t % R);
`endif
      end else if (d && !u && s != 0) begin
         t  = m_cnt - MINV - s;
         un = (t < 0);
`ifdef BOUNDED_COUNTER_SAT_EN
         nxt = un ? MINV : m_cnt - s;
`else
         nxt = MINV + ((t + R) % R);
`endif
      end
   endtask

   task automatic cyc(input string tag, input bit r, input bit l, input bit u, input bit d,
                      input int s, input int lv);
      int nxt;
      bit ov, un;
      logic [31:0] sv, lvv;
      sv  = s;
      lvv = lv;
      reset_i        = r;
      bus.load_i     = l;
      bus.up_i       = u;
      bus.down_i     = d;
      bus.step_i     = sv[W-1:0];
      bus.load_val_i = lvv[W-1:0];
      model_eval(r, l, u, d, s, lv, nxt, ov, un);
      #1;
      chk({tag, "/next_count"}, bus.next_count_o, nxt);
      @(posedge clk_i);
      #1;
      m_cnt = nxt;
      chk({tag, "/count"},     bus.count_o,     m_cnt);
      chk({tag, "/overflow"},  bus.overflow_o,  ov);
      chk({tag, "/underflow"}, bus.underflow_o, un);
      chk({tag, "/at_max"},    bus.at_max_o,    m_cnt == MAXV);
      chk({tag, "/at_min"},    bus.at_min_o,    m_cnt == MINV);
   endtask

   initial begin
      reset_i        = 1'b1;
      bus.up_i       = 1'b0;
      bus.down_i     = 1'b0;
      bus.step_i     = '0;
      bus.load_i     = 1'b0;
      bus.load_val_i = '0;

      cyc("reset0", 1, 0, 0, 0, 0, 0);
      cyc("reset1", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc("count_up", 0, 0, 1, 0, 1, 0);

      cyc("load10",      0, 1, 0, 0, 0, 10);
      cyc("up3_wrap",    0, 0, 1, 0, 3, 0);
      cyc("up_full_R",   0, 0, 1, 0, 10, 0);
      cyc("hold_quiet",  0, 0, 0, 0, 0, 0);
      cyc("load3",       0, 1, 0, 0, 0, 3);
      cyc("down4_wrap",  0, 0, 0, 1, 4, 0);
      cyc("updown_hold", 0, 0, 1, 1, 2, 0);
      cyc("step0_hold",  0, 0, 1, 0, 0, 0);
      cyc("down_full_R", 0, 0, 0, 1, 10, 0);
      cyc("load0_clamp", 0, 1, 0, 0, 0, 0);
      cyc("load14_clamp",0, 1, 0, 0, 0, 14);
      cyc("load_over_up",0, 1, 1, 0, 3, 7);

      cyc("stream0",     0, 0, 1, 0, 4, 0);
      cyc("stream1",     0, 0, 1, 0, 4, 0);
      cyc("stream_rst",  1, 0, 1, 0, 4, 0);
      cyc("stream2",     0, 0, 1, 0, 4, 0);

      cyc("sat_load10",  0, 1, 0, 0, 0, 10);
      cyc("sat_up3",     0, 0, 1, 0, 3, 0);
      cyc("sat_load11",  0, 1, 0, 0, 0, 11);
      cyc("sat_up1",     0, 0, 1, 0, 1, 0);
      cyc("sat_load9",   0, 1, 0, 0, 0, 9);
      cyc("sat_up2",     0, 0, 1, 0, 2, 0);
      cyc("land_min_ld", 0, 1, 0, 0, 0, 4);
      cyc("land_min",    0, 0, 0, 1, 2, 0);

      for (int i = 0; i < 250; i++) begin
         cyc("random",
             ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 5) == 0),
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1,
             int'($urandom_range(0, R)),
             int'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bounded_counter.md
# bounded_counter

Parametrised up/down counter with a programmable range [min_val_p, max_val_p], a run-time step size, a synchronous parallel load, and registered overflow/underflow event pulses. It generalises the plain up/down counter for frame/line/pixel position tracking and window indexing in the vision pipeline, where counts must stay within a non-power-of-two range. Boundary behaviour is wrap-around by default, or saturation when compiled with the configuration macro.

## Interface
- width_p, default 8: count width in bits.
- min_val_p, default 0: lowest legal count.
- max_val_p, default 2**width_p-1: highest legal count.
- reset_val_p, default 0: count value after reset.
- Elaboration-time `$error` unless min_val_p < max_val_p and min_val_p <= reset_val_p <= max_val_p.
- clk_i  input  1  the single clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- up_i  input  1  request to increment by step_i.
- down_i  input  1  request to decrement by step_i.
- step_i  input  width_p  step magnitude; legal range 0..R, where R = max_val_p-min_val_p+1.
- load_i  input  1  synchronous load of load_val_i.
- load_val_i  input  width_p  value to load, clamped into range.
- count_o  output  width_p  registered count.
- next_count_o  output  width_p  combinational value count_o takes at the next edge.
- at_max_o  output  1  combinational: count_o == max_val_p.
- at_min_o  output  1  combinational: count_o == min_val_p.
- overflow_o  output  1  registered one-cycle pulse: the last update crossed max_val_p.
- underflow_o  output  1  registered one-cycle pulse: the last update crossed min_val_p.

## Operation
- Priority, highest first: reset_i, load_i, exclusive up_i, exclusive down_i, hold.
- Hold applies when up_i and down_i are both high, both low, or step_i == 0; in all these cases no event pulse is raised.
- Load:
  - next = min_val_p if load_val_i < min_val_p.
  - next = max_val_p if load_val_i > max_val_p.
  - otherwise next = load_val_i.
  - Load never raises an event pulse.
- Arithmetic is done at width_p+1 bits, so no intermediate result truncates.
- Up, wrap mode:
  - s = count + step_i.
  - If s > max_val_p: next = s - R and overflow is set.
  - Otherwise next = s.
- Down, wrap mode:
  - If count < min_val_p + step_i: next = count - step_i + R and underflow is set.
  - Otherwise next = count - step_i.
- A step of exactly R returns the count to its current value and still raises the event pulse.
- A step_i greater than R is illegal, and results are undefined. The bench never drives it. An assertion flags it in simulation only.
- Reset forces next_count_o = reset_val_p, with overflow_o and underflow_o = 0.

## Timing
- count_o, overflow_o and underflow_o are registered and update together on the rising edge.
- Latency from input to count_o is one cycle.
- next_count_o, at_max_o and at_min_o are combinational.
- Event pulses last exactly one cycle and are aligned with the count_o value they describe.
- Back-to-back wraps produce back-to-back pulses.
- Values on the first cycle after reset is asserted: count_o = reset_val_p, overflow_o = 0, underflow_o = 0, at_max_o and at_min_o derived from reset_val_p.
- Reset asserted while another operation is in progress overrides load and count for that edge.

## Configuration
- BOUNDED_COUNTER_SAT_EN defined: saturating mode.
  - An up step that would exceed max_val_p sets next = max_val_p.
  - A down step that would go below min_val_p sets next = min_val_p.
  - overflow_o or underflow_o still pulses when clipping occurs.
  - A step that lands exactly on a bound does not pulse.
- Undefined: wrap mode, as described under Operation.

## Structure
- Shared package counter_pkg holds:
  - typedef enum {CNT_HOLD, CNT_LOAD, CNT_UP, CNT_DOWN} cnt_op_e.
  - A range-check helper function used by elaboration checks and assertions.
- Sub-module bounded_step: combinational. Takes count, step, direction and the range bounds; returns the next value plus an event flag. It contains the wrap/saturate selection and is unit-testable on its own.
- The top level contains:
  - the operation decode into cnt_op_e;
  - the load clamp;
  - the count, overflow and underflow registers.

## Test plan
Bench parameters: width_p=4, min_val_p=2, max_val_p=11, reset_val_p=5, so R=10.
- Reset: hold reset_i for 2 cycles -> count_o=5, overflow_o=0, underflow_o=0, at_max_o=0, at_min_o=0. Then up_i=1, step_i=1 for 6 cycles -> count_o=11 with at_max_o=1, no pulse.
- Wrap up: count=10, up_i=1, step_i=3 -> count_o=3 and overflow_o=1 for exactly one cycle. A following cycle with step_i=10 -> count_o=3 and overflow_o=1 again.
- Wrap down: count=3, down_i=1, step_i=4 -> count_o=9, underflow_o=1. With up_i=down_i=1 -> count holds, no pulse.
- Load clamp: load_val_i=0 -> 2. load_val_i=14 -> 11. load_i together with up_i and load_val_i=7 -> 7.
- Reset mid-count: up_i=1 streaming, reset_i asserted for one cycle -> next_count_o=5 that cycle and count_o=5 the next, pulses low.
- With BOUNDED_COUNTER_SAT_EN defined: count=10, up_i=1, step_i=3 -> 11 with overflow_o=1. count=11, up_i=1, step_i=1 -> 11 with overflow_o=1. count=9, up_i=1, step_i=2 -> 11 with no pulse.
